// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop sync, stability-counter debounce,
// clean level plus press/release/long-press single-cycle pulses.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  localparam logic        REL_LVL = KEY_ACTIVE_LOW;
  localparam logic [31:0] D_LAST  = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] D_INIT  = 32'(DEBOUNCE_CYCLES);
  localparam logic [31:0] L_HIT   = 32'(LONG_CYCLES - 1);
  localparam logic [31:0] H_MAX   = '1;

  logic        s1, s2, p;
  state_t      state, state_n;
  logic [31:0] dcnt, dcnt_n;
  logic [31:0] hcnt, hcnt_n;
  logic        lvl_n, press_n, rel_n, long_n;

  // sync flops idle at the released pin level so reset looks like no press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= REL_LVL;
      s2 <= REL_LVL;
    end else begin
      s1 <= key_in;
      s2 <= s1;
    end
  end

  assign p = s2 ^ REL_LVL;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      dcnt        <= '0;
      hcnt        <= '0;
      key_state   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
    end else begin
      state       <= state_n;
      dcnt        <= dcnt_n;
      hcnt        <= hcnt_n;
      key_state   <= lvl_n;
      key_press   <= press_n;
      key_release <= rel_n;
      key_long    <= long_n;
    end
  end

  always_comb begin
    state_n = state;
    dcnt_n  = dcnt;
    hcnt_n  = hcnt;
    lvl_n   = key_state;
    press_n = 1'b0;
    rel_n   = 1'b0;
    long_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (p) begin
          state_n = PRESS_WAIT;
          dcnt_n  = '0;
        end
      end
      PRESS_WAIT: begin
        if (!p) begin
          state_n = IDLE;
        end else if (dcnt == D_LAST) begin
          state_n = PRESSED;
          lvl_n   = 1'b1;
          press_n = 1'b1;
          hcnt_n  = D_INIT;
        end else begin
          dcnt_n = dcnt + 32'd1;
        end
      end
      PRESSED: begin
        if (!p) begin
          state_n = RELEASE_WAIT;
          dcnt_n  = '0;
        end else if (hcnt != H_MAX) begin
          // hcnt only climbs within a press, so this hits once
          hcnt_n = hcnt + 32'd1;
          long_n = (hcnt + 32'd1) == L_HIT;
        end
      end
      RELEASE_WAIT: begin
        if (p) begin
          state_n = PRESSED;
        end else if (dcnt == D_LAST) begin
          state_n = IDLE;
          lvl_n   = 1'b0;
          rel_n   = 1'b1;
        end else begin
          dcnt_n = dcnt + 32'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios plus random pin bursts
// checked cycle by cycle against a run-length reference model.
module tb_key_debounce;

  localparam int D = 8;
  localparam int L = 40;

  logic clk = 1'b0;
  logic rst;
  logic key_in;
  logic key_state, key_press, key_release, key_long;

  int total = 0;
  int bad   = 0;

  key_debounce #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES(L),
    .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_in(key_in),
    .key_state(key_state),
    .key_press(key_press),
    .key_release(key_release),
    .key_long(key_long)
  );

  always #5 clk = ~clk;

  // model: the level flips once the pressed-ness seen two samples
  // back has disagreed with it for D+1 consecutive samples
  logic pin1, pin2;
  logic m_lvl, m_press, m_rel, m_long;
  int   run, hold;
  logic pr;
  assign pr = ~pin2;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pin1    <= 1'b1;
      pin2    <= 1'b1;
      m_lvl   <= 1'b0;
      m_press <= 1'b0;
      m_rel   <= 1'b0;
      m_long  <= 1'b0;
      run     <= 0;
      hold    <= 0;
    end else begin
      pin1    <= key_in;
      pin2    <= pin1;
      m_press <= 1'b0;
      m_rel   <= 1'b0;
      m_long  <= 1'b0;
      if (pr != m_lvl) begin
        if (run == D) begin
          m_lvl <= pr;
          run   <= 0;
          if (pr) begin
            m_press <= 1'b1;
            hold    <= D;
          end else begin
            m_rel <= 1'b1;
          end
        end else begin
          run <= run + 1;
        end
      end else begin
        run <= 0;
        if (m_lvl && run == 0) begin
          hold <= hold + 1;
          if (hold + 1 == L - 1) m_long <= 1'b1;
        end
      end
    end
  end

  logic [3:0] got, exp_v;
  assign got   = {key_state, key_press, key_release, key_long};
  assign exp_v = {m_lvl, m_press, m_rel, m_long};

  task automatic test_reset();
    key_in = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (got !== 4'b0000) begin
      bad++;
      $display("FAIL reset_held got=%b exp=0000", got);
    end
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      total++;
      if (got !== 4'b0000) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=0000", i, got);
      end
    end
  endtask

  task automatic test_press();
    int at_p = -1;
    int at_r = -1;
    key_in = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      total++;
      if (got !== exp_v) begin
        bad++;
        $display("FAIL press_cyc i=%0d got=%b exp=%b", i, got, exp_v);
      end
      if (key_press && at_p < 0) at_p = i;
    end
    total++;
    if (at_p < 10 || at_p > 11) begin
      bad++;
      $display("FAIL press_latency got=%0d exp=10..11", at_p);
    end
    total++;
    if (key_state !== 1'b1) begin
      bad++;
      $display("FAIL press_level got=%b exp=1", key_state);
    end
    key_in = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      total++;
      if (got !== exp_v) begin
        bad++;
        $display("FAIL unpress_cyc i=%0d got=%b exp=%b", i, got, exp_v);
      end
      if (key_release && at_r < 0) at_r = i;
    end
    total++;
    if (at_r < 10 || at_r > 11) begin
      bad++;
      $display("FAIL release_latency got=%0d exp=10..11", at_r);
    end
  endtask

  task automatic test_bounce();
    logic lv[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int   ln[4] = '{5, 3, 4, 20};
    int   ev = 0;
    for (int s = 0; s < 4; s++) begin
      key_in = lv[s];
      for (int i = 0; i < ln[s]; i++) begin
        @(negedge clk);
        total++;
        if (got !== exp_v) begin
          bad++;
          $display("FAIL bounce_cyc s=%0d got=%b exp=%b", s, got, exp_v);
        end
        if (got != 4'b0000) ev++;
      end
    end
    total++;
    if (ev != 0) begin
      bad++;
      $display("FAIL bounce_quiet got=%0d exp=0", ev);
    end
  endtask

  task automatic test_long();
    int np = 0, nl = 0, nr = 0;
    int tp = -1, tl = -1, tr = -1;
    key_in = 1'b0;
    for (int i = 1; i <= 85; i++) begin
      if (i == 61) key_in = 1'b1;
      @(negedge clk);
      total++;
      if (got !== exp_v) begin
        bad++;
        $display("FAIL long_cyc i=%0d got=%b exp=%b", i, got, exp_v);
      end
      if (key_press) begin np++; tp = i; end
      if (key_long) begin nl++; tl = i; end
      if (key_release) begin nr++; tr = i; end
    end
    total++;
    if (np != 1 || nl != 1 || nr != 1) begin
      bad++;
      $display("FAIL long_counts got=%0d/%0d/%0d exp=1/1/1", np, nl, nr);
    end
    total++;
    if (tl - tp != L - 1 - D) begin
      bad++;
      $display("FAIL long_delay got=%0d exp=%0d", tl - tp, L - 1 - D);
    end
    total++;
    if (tr - 60 < 10 || tr - 60 > 11) begin
      bad++;
      $display("FAIL long_release got=%0d exp=10..11", tr - 60);
    end
  endtask

  task automatic test_release_bounce();
    int np = 0, nr = 0, low = 0;
    key_in = 1'b0;
    for (int i = 1; i <= 44; i++) begin
      if (i == 21) key_in = 1'b1;
      if (i == 25) key_in = 1'b0;
      @(negedge clk);
      total++;
      if (got !== exp_v) begin
        bad++;
        $display("FAIL relb_cyc i=%0d got=%b exp=%b", i, got, exp_v);
      end
      if (key_press) np++;
      if (key_release) nr++;
      if (i > 12 && !key_state) low++;
    end
    total++;
    if (np != 1 || nr != 0 || low != 0) begin
      bad++;
      $display("FAIL relb_counts got=%0d/%0d/%0d exp=1/0/0", np, nr, low);
    end
  endtask

  task automatic test_reset_mid();
    int at_p = -1;
    total++;
    if (key_state !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre got=%b exp=1", key_state);
    end
    rst = 1'b1;
    #1;
    total++;
    if (got !== 4'b0000) begin
      bad++;
      $display("FAIL mid_async got=%b exp=0000", got);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      total++;
      if (got !== exp_v) begin
        bad++;
        $display("FAIL mid_cyc i=%0d got=%b exp=%b", i, got, exp_v);
      end
      if (key_press && at_p < 0) at_p = i;
    end
    total++;
    if (at_p < 10 || at_p > 11) begin
      bad++;
      $display("FAIL mid_repress got=%0d exp=10..11", at_p);
    end
    key_in = 1'b1;
    repeat (15) @(negedge clk);
  endtask

  task automatic test_random();
    int len;
    for (int b = 0; b < 80; b++) begin
      key_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) len = $urandom_range(20, 60);
      else len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        total++;
        if (got !== exp_v) begin
          bad++;
          $display("FAIL rand_cyc b=%0d got=%b exp=%b", b, got, exp_v);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_long();
    test_release_bounce();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
